sopc_pio_poll_ctrl: RTL and testbench

- Sequencer and arbiter in front of the 8-bit input PIO slave.
- The PIO has a fixed 1-cycle registered read latency and no read strobe. This block shares its single address/readdata port between a host Avalon-MM slave port (CPU) and an internal periodic poll engine.
- The poll engine compares successive samples of PIO register 0 and pushes each changed value into a small event FIFO that drives a level interrupt.
- Sits between the CPU interconnect and the PIO inside the SOPC subsystem.

---
 rtl/sopc_pio_poll_ctrl.sv | 137 +++++++++++++
 tb/tb_sopc_pio_poll_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_pio_poll_ctrl.sv
// sopc_pio_poll_ctrl: shares the 8-bit input PIO's single read port between the host
// Avalon-MM slave and a periodic poll engine that queues changed samples as events.
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   hs_address/read    host word address (3 = local status) and read request
//   hs_waitrequest     high whenever a PIO access is in flight
//   hs_readdata/valid  host read data, valid pulse two cycles after acceptance
//   pio_address        address to the PIO (registered read, 1-cycle latency)
//   pio_readdata       PIO data for the previous cycle's pio_address
//   evt_data/valid     head of the change-event FIFO, FIFO not empty
//   evt_ready          pops the FIFO head when evt_valid is high
//   irq                level interrupt, mirrors evt_valid
module sopc_pio_poll_ctrl #(
    parameter int POLL_DIV   = 1000,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  hs_address,
    input  logic        hs_read,
    output logic        hs_waitrequest,
    output logic [31:0] hs_readdata,
    output logic        hs_readdatavalid,
    output logic [1:0]  pio_address,
    input  logic [31:0] pio_readdata,
    output logic [7:0]  evt_data,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic        irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HOST_WAIT, POLL_WAIT} state_t;

    state_t           state;
    logic [15:0]      timer;
    logic             poll_pending;
    logic             baseline_valid;
    logic             overflow;
    logic [7:0]       last_sample;
    logic [1:0]       addr_q;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       sample;
    logic [31:0]      status;
    logic             expire;
    logic             poll_start;
    logic             push_req;
    logic             full;
    logic             pop;
    logic             push;

    assign sample     = pio_readdata[7:0];
    assign status     = {overflow, {(31-CNT_W){1'b0}}, count};
    assign expire     = timer == 16'(POLL_DIV - 1);
    assign poll_start = state == IDLE && !hs_read && poll_pending;
    assign push_req   = state == POLL_WAIT && baseline_valid && sample != last_sample;
    assign full       = count == CNT_W'(FIFO_DEPTH);
    assign pop        = evt_ready && evt_valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = push_req && (!full || pop);

    assign hs_waitrequest = state != IDLE;
    // Address 3 is local, so the PIO sees 0 (the poll register) instead.
    assign pio_address    = (state == IDLE && hs_read && hs_address != 2'd3) ? hs_address : 2'd0;
    assign evt_data       = mem[rd_ptr];
    assign evt_valid      = count != '0;
    assign irq            = evt_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            timer            <= '0;
            poll_pending     <= 1'b0;
            baseline_valid   <= 1'b0;
            overflow         <= 1'b0;
            last_sample      <= '0;
            addr_q           <= '0;
            hs_readdata      <= '0;
            hs_readdatavalid <= 1'b0;
        end else begin
            timer            <= expire ? '0 : timer + 16'd1;
            // A new expiry wins over the clear so a back-to-back request is not lost.
            poll_pending     <= expire || (poll_pending && !poll_start);
            hs_readdatavalid <= state == HOST_WAIT;
            case (state)
                IDLE: begin
                    if (hs_read) begin
                        addr_q <= hs_address;
                        state  <= HOST_WAIT;
                    end else if (poll_pending) begin
                        state  <= POLL_WAIT;
                    end
                end
                HOST_WAIT: begin
                    hs_readdata <= addr_q == 2'd3 ? status : pio_readdata;
                    if (addr_q == 2'd3)
                        overflow <= 1'b0;
                    state <= IDLE;
                end
                POLL_WAIT: begin
                    if (!baseline_valid) begin
                        baseline_valid <= 1'b1;
                        last_sample    <= sample;
                    end else if (sample != last_sample) begin
                        last_sample <= sample;
                        if (full && !pop)
                            overflow <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sample;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_sopc_pio_poll_ctrl.sv
// tb_sopc_pio_poll_ctrl: directed bench for sopc_pio_poll_ctrl with a registered PIO model.
// Ports: none (top-level bench).
module tb_sopc_pio_poll_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  hs_address = '0;
    logic        hs_read = 1'b0;
    logic        hs_waitrequest;
    logic [31:0] hs_readdata;
    logic        hs_readdatavalid;
    logic [1:0]  pio_address;
    logic [31:0] pio_readdata = '0;
    logic [7:0]  evt_data;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic        irq;
    logic [7:0]  in_port = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    sopc_pio_poll_ctrl #(.POLL_DIV(8), .FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .hs_address(hs_address), .hs_read(hs_read), .hs_waitrequest(hs_waitrequest),
        .hs_readdata(hs_readdata), .hs_readdatavalid(hs_readdatavalid),
        .pio_address(pio_address), .pio_readdata(pio_readdata),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    // PIO slave: registered read, data follows the previous cycle's address.
    always @(posedge clk)
        pio_readdata <= pio_address == 2'd0 ? {24'h0, in_port} :
                        pio_address == 2'd1 ? 32'hCAFE_0001 : 32'h1234_5602;

    // Cycles since reset release; poll requests rise when this is a multiple of 8.
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (hs_waitrequest && n < 20) begin
            tick();
            n++;
        end
        if (hs_waitrequest) check({tag, " idle timeout"}, 32'd0, 32'd1);
    endtask

    // Returns at the negedge right after a complete poll sample.
    task automatic wait_poll(input string tag);
        int n = 0;
        wait_idle(tag);
        while (!hs_waitrequest && n < 30) begin
            tick();
            n++;
        end
        if (!hs_waitrequest) check({tag, " poll timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    task automatic host_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        wait_idle(tag);
        hs_read = 1'b1;
        hs_address = addr;
        #1;
        check({tag, " accept wait"}, 32'(hs_waitrequest), 32'd0);
        check({tag, " pio addr"}, 32'(pio_address), addr == 2'd3 ? 32'd0 : 32'(addr));
        tick();
        hs_read = 1'b0;
        check({tag, " stall"}, 32'(hs_waitrequest), 32'd1);
        check({tag, " early valid"}, 32'(hs_readdatavalid), 32'd0);
        tick();
        check({tag, " valid"}, 32'(hs_readdatavalid), 32'd1);
        check({tag, " data"}, hs_readdata, exp);
    endtask

    task automatic pop_evt;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " waitreq"}, 32'(hs_waitrequest), 32'd0);
        check({tag, " rdvalid"}, 32'(hs_readdatavalid), 32'd0);
        check({tag, " rdata"}, hs_readdata, 32'd0);
        check({tag, " pio addr"}, 32'(pio_address), 32'd0);
        check({tag, " evt_valid"}, 32'(evt_valid), 32'd0);
        check({tag, " evt_data"}, 32'(evt_data), 32'd0);
        check({tag, " irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] vals [5];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // First poll is baseline only.
        n = 0;
        while (!hs_waitrequest && n < 30) begin
            tick();
            n++;
        end
        check("first poll cycle", 32'(n >= 8 && n <= 10), 32'd1);
        tick();
        check("baseline evt_valid", 32'(evt_valid), 32'd0);
        host_read("status empty", 2'd3, 32'h0000_0000);

        in_port = 8'h5A;
        wait_poll("chg 5A");
        check("5A evt_valid", 32'(evt_valid), 32'd1);
        check("5A evt_data", 32'(evt_data), 32'h5A);
        check("5A irq", 32'(irq), 32'd1);
        pop_evt();
        check("5A popped", 32'(evt_valid), 32'd0);
        wait_poll("same 5A");
        check("unchanged no evt", 32'(evt_valid), 32'd0);

        in_port = 8'h3C;
        host_read("rd addr0", 2'd0, 32'h0000_003C);
        tick();
        check("rd pulse end", 32'(hs_readdatavalid), 32'd0);
        host_read("rd addr1", 2'd1, 32'hCAFE_0001);
        wait_poll("chg 3C");
        check("3C evt_data", 32'(evt_data), 32'h3C);
        pop_evt();
        check("3C popped", 32'(evt_valid), 32'd0);

        // Host read in the cycle poll_pending rises: host first, poll right after.
        wait_idle("prio");
        n = 0;
        while (cyc % 8 != 0 && n < 20) begin
            tick();
            n++;
        end
        in_port = 8'h77;
        hs_read = 1'b1;
        hs_address = 2'd2;
        #1;
        check("prio accept", 32'(hs_waitrequest), 32'd0);
        check("prio host addr", 32'(pio_address), 32'd2);
        tick();
        hs_read = 1'b0;
        check("prio host wait", 32'(hs_waitrequest), 32'd1);
        tick();
        check("prio valid", 32'(hs_readdatavalid), 32'd1);
        check("prio data", hs_readdata, 32'h1234_5602);
        check("prio poll idle", 32'(hs_waitrequest), 32'd0);
        check("prio poll addr", 32'(pio_address), 32'd0);
        tick();
        check("prio poll wait", 32'(hs_waitrequest), 32'd1);
        tick();
        check("prio evt_valid", 32'(evt_valid), 32'd1);
        check("prio evt_data", 32'(evt_data), 32'h77);
        pop_evt();

        // Overflow: five changes into a four-entry FIFO.
        for (int i = 0; i < 5; i++) begin
            in_port = vals[i];
            wait_poll("fill");
        end
        host_read("status ovf", 2'd3, 32'h8000_0004);
        host_read("status clr", 2'd3, 32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fifo order %0d", i), 32'(evt_data), 32'(vals[i]));
            pop_evt();
        end
        check("fifo drained", 32'(evt_valid), 32'd0);
        wait_poll("after drop");
        check("dropped still baseline", 32'(evt_valid), 32'd0);

        // Reset in HOST_WAIT aborts the read and flushes the FIFO.
        in_port = 8'h99;
        wait_poll("chg 99");
        check("99 evt_valid", 32'(evt_valid), 32'd1);
        wait_idle("rst");
        hs_read = 1'b1;
        hs_address = 2'd0;
        tick();
        hs_read = 1'b0;
        check("rst in host wait", 32'(hs_waitrequest), 32'd1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("mid reset");
        repeat (2) begin
            tick();
            check("rst no valid", 32'(hs_readdatavalid), 32'd0);
        end
        reset_n = 1'b1;
        tick();
        check("post rst no valid", 32'(hs_readdatavalid), 32'd0);
        wait_poll("post rst baseline");
        check("post rst baseline", 32'(evt_valid), 32'd0);
        in_port = 8'hAB;
        wait_poll("chg AB");
        check("AB evt_valid", 32'(evt_valid), 32'd1);
        check("AB evt_data", 32'(evt_data), 32'hAB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
